// File: rtl/binary_centroid.sv
// binary_centroid: per-frame centroid, pixel count and bounding box of the
// binary mask stream. Coordinates are rebuilt from VGA_DE/VGA_VS. The sums
// and bbox for a frame are snapshotted on the VS rising edge. A restoring
// divider, one quotient bit per cycle, then produces floor(sum/count) for x
// and y. Results are held until the next RESULT_VALID pulse.
// Optional feature macro: BINARY_CENTROID_BBOX_EN enables the bounding-box
// trackers. When it is undefined, the BBOX_* outputs are tied to zero.
module binary_centroid #(
    parameter int H_BITS    = 11,
    parameter int V_BITS    = 10,
    parameter int MIN_COUNT = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     VGA_VS,
    input  logic                     VGA_DE,
    input  logic                     BINARY_FLAG,
    output logic [H_BITS-1:0]        CENTROID_X,
    output logic [V_BITS-1:0]        CENTROID_Y,
    output logic [H_BITS+V_BITS-1:0] PIXEL_COUNT,
    output logic [H_BITS-1:0]        BBOX_X0,
    output logic [H_BITS-1:0]        BBOX_X1,
    output logic [V_BITS-1:0]        BBOX_Y0,
    output logic [V_BITS-1:0]        BBOX_Y1,
    output logic                     TARGET_FOUND,
    output logic                     RESULT_VALID
);

    localparam int CW  = H_BITS + V_BITS;            // pixel count width
    localparam int SWX = 2 * H_BITS + V_BITS;        // sum_x width
    localparam int SWY = H_BITS + 2 * V_BITS;        // sum_y width
    localparam int DW  = (SWX > SWY) ? SWX : SWY;    // divider shift register
    localparam int KW  = $clog2(DW + 1);             // divider step counter

    localparam logic [CW-1:0] MIN_CNT_C = CW'(MIN_COUNT);

    localparam logic [2:0] ST_WAIT_FRAME = 3'd0;
    localparam logic [2:0] ST_ACCUM      = 3'd1;
    localparam logic [2:0] ST_DIV_X      = 3'd2;
    localparam logic [2:0] ST_DIV_Y      = 3'd3;
    localparam logic [2:0] ST_PUBLISH    = 3'd4;

    // One restoring-division step: returns {quotient_bit, new_remainder}.
    // The remainder is always below the divisor, so it fits in CW bits.
    function automatic logic [CW:0] div_step(
        input logic [CW-1:0] rem,
        input logic          num_msb,
        input logic [CW-1:0] dvs
    );
        logic [CW:0]   trial;
        logic [CW-1:0] diff;
        trial = {rem, num_msb};
        diff  = trial[CW-1:0] - dvs;
        if (trial >= {1'b0, dvs}) begin
            div_step = {1'b1, diff};
        end else begin
            div_step = {1'b0, trial[CW-1:0]};
        end
    endfunction

    logic [2:0]        state;
    logic [KW-1:0]     div_cnt;

    logic              vs_p1;
    logic              vs_edge_p1;
    logic              de_p1;

    logic [H_BITS-1:0] x_cnt;
    logic [V_BITS-1:0] y_cnt;

    logic [CW-1:0]     acc_cnt;
    logic [SWX-1:0]    acc_sx;
    logic [SWY-1:0]    acc_sy;

    logic [CW-1:0]     snap_cnt;
    logic [SWY-1:0]    snap_sy;
    logic [DW-1:0]     div_num;
    logic [CW-1:0]     div_rem;
    logic [H_BITS-1:0] quo_x;

    logic [CW:0]       step_res;
    logic [DW-1:0]     next_num;

    logic              hit;
    logic              clr_acc;
    logic              take_snap;
    logic              snap_go;
    logic              div_last;
    logic              div_x_end;
    logic              pub_target;
    logic              pub_empty;

    assign hit        = VGA_DE && BINARY_FLAG;
    assign clr_acc    = vs_edge_p1;
    // A VS edge outside WAIT_FRAME always closes a frame, abandoning any division
    assign take_snap  = vs_edge_p1 && (state != ST_WAIT_FRAME);
    // The non-zero guard keeps the divider from ever seeing a zero divisor
    assign snap_go    = (acc_cnt >= MIN_CNT_C) && (acc_cnt != '0);
    assign div_last   = (div_cnt == '0);
    assign div_x_end  = (state == ST_DIV_X) && div_last && !take_snap;
    assign pub_target = (state == ST_DIV_Y) && div_last && !take_snap;
    assign pub_empty  = take_snap && !snap_go;

    assign step_res   = div_step(div_rem, div_num[DW-1], snap_cnt);
    assign next_num   = {div_num[DW-2:0], step_res[CW]};

    // Register sync strobes and detect the VS rising edge
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vs_p1      <= 1'b0;
            vs_edge_p1 <= 1'b0;
            de_p1      <= 1'b0;
        end else begin
            vs_p1      <= VGA_VS;
            vs_edge_p1 <= VGA_VS && !vs_p1;
            de_p1      <= VGA_DE;
        end
    end

    // Pixel coordinates: x counts active pixels, y counts DE falling edges
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (VGA_DE) begin
                x_cnt <= x_cnt + H_BITS'(1);
            end else begin
                x_cnt <= '0;
            end
            if (clr_acc) begin
                y_cnt <= '0;
            end else if (de_p1 && !VGA_DE) begin
                y_cnt <= y_cnt + V_BITS'(1);
            end
        end
    end

    // Count and coordinate sums of set pixels for the frame in progress
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc_cnt <= '0;
            acc_sx  <= '0;
            acc_sy  <= '0;
        end else if (clr_acc) begin
            acc_cnt <= '0;
            acc_sx  <= '0;
            acc_sy  <= '0;
        end else if (hit) begin
            acc_cnt <= acc_cnt + CW'(1);
            acc_sx  <= acc_sx + SWX'(x_cnt);
            acc_sy  <= acc_sy + SWY'(y_cnt);
        end
    end

    // Frame FSM and divider step counter
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= ST_WAIT_FRAME;
            div_cnt      <= '0;
            RESULT_VALID <= 1'b0;
        end else begin
            RESULT_VALID <= pub_empty || pub_target;
            if (take_snap) begin
                state   <= snap_go ? ST_DIV_X : ST_PUBLISH;
                div_cnt <= KW'(SWX - 1);
            end else begin
                case (state)
                    ST_WAIT_FRAME: begin
                        if (vs_edge_p1) begin
                            state <= ST_ACCUM;
                        end
                    end
                    ST_DIV_X: begin
                        if (div_last) begin
                            state   <= ST_DIV_Y;
                            div_cnt <= KW'(SWY - 1);
                        end else begin
                            div_cnt <= div_cnt - KW'(1);
                        end
                    end
                    ST_DIV_Y: begin
                        if (div_last) begin
                            state <= ST_PUBLISH;
                        end else begin
                            div_cnt <= div_cnt - KW'(1);
                        end
                    end
                    ST_PUBLISH: state <= ST_ACCUM;
                    default:    state <= ST_ACCUM;
                endcase
            end
        end
    end

    // Snapshot and restoring divider datapath (dividend MSB-aligned in div_num)
    always_ff @(posedge CLK) begin
        if (take_snap) begin
            snap_cnt <= acc_cnt;
            snap_sy  <= acc_sy;
            div_num  <= DW'(acc_sx) << (DW - SWX);
            div_rem  <= '0;
        end else if (div_x_end) begin
            quo_x    <= next_num[H_BITS-1:0];
            div_num  <= DW'(snap_sy) << (DW - SWY);
            div_rem  <= '0;
        end else if (state == ST_DIV_X || state == ST_DIV_Y) begin
            div_num  <= next_num;
            div_rem  <= step_res[CW-1:0];
        end
    end

    // Published results, updated only on the RESULT_VALID cycle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            CENTROID_X   <= '0;
            CENTROID_Y   <= '0;
            PIXEL_COUNT  <= '0;
            TARGET_FOUND <= 1'b0;
        end else if (pub_empty) begin
            CENTROID_X   <= '0;
            CENTROID_Y   <= '0;
            PIXEL_COUNT  <= acc_cnt;
            TARGET_FOUND <= 1'b0;
        end else if (pub_target) begin
            CENTROID_X   <= quo_x;
            CENTROID_Y   <= next_num[V_BITS-1:0];
            PIXEL_COUNT  <= snap_cnt;
            TARGET_FOUND <= 1'b1;
        end
    end

`ifdef BINARY_CENTROID_BBOX_EN
    logic [H_BITS-1:0] acc_x0;
    logic [H_BITS-1:0] acc_x1;
    logic [V_BITS-1:0] acc_y0;
    logic [V_BITS-1:0] acc_y1;
    logic [H_BITS-1:0] snap_x0;
    logic [H_BITS-1:0] snap_x1;
    logic [V_BITS-1:0] snap_y0;
    logic [V_BITS-1:0] snap_y1;

    // Min/max trackers; an empty frame leaves min all-ones and max zero
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc_x0 <= '1;
            acc_x1 <= '0;
            acc_y0 <= '1;
            acc_y1 <= '0;
        end else if (clr_acc) begin
            acc_x0 <= '1;
            acc_x1 <= '0;
            acc_y0 <= '1;
            acc_y1 <= '0;
        end else if (hit) begin
            if (x_cnt < acc_x0) acc_x0 <= x_cnt;
            if (x_cnt > acc_x1) acc_x1 <= x_cnt;
            if (y_cnt < acc_y0) acc_y0 <= y_cnt;
            if (y_cnt > acc_y1) acc_y1 <= y_cnt;
        end
    end

    // Hold the closed frame's bbox while the divider runs
    always_ff @(posedge CLK) begin
        if (take_snap) begin
            snap_x0 <= acc_x0;
            snap_x1 <= acc_x1;
            snap_y0 <= acc_y0;
            snap_y1 <= acc_y1;
        end
    end

    // Published bbox, zero for frames below the target threshold
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            BBOX_X0 <= '0;
            BBOX_X1 <= '0;
            BBOX_Y0 <= '0;
            BBOX_Y1 <= '0;
        end else if (pub_empty) begin
            BBOX_X0 <= '0;
            BBOX_X1 <= '0;
            BBOX_Y0 <= '0;
            BBOX_Y1 <= '0;
        end else if (pub_target) begin
            BBOX_X0 <= snap_x0;
            BBOX_X1 <= snap_x1;
            BBOX_Y0 <= snap_y0;
            BBOX_Y1 <= snap_y1;
        end
    end
`else
    assign BBOX_X0 = '0;
    assign BBOX_X1 = '0;
    assign BBOX_Y0 = '0;
    assign BBOX_Y1 = '0;
`endif

endmodule

// File: tb/tb_binary_centroid.sv
// Scoreboard bench for binary_centroid: frames are generated from a pixel
// mask. The expected result of each frame is computed arithmetically and is
// queued with its due cycle when VS rises. A monitor pops and compares the
// queued result whenever RESULT_VALID is seen.
module tb_binary_centroid;
    localparam int H_BITS     = 11;
    localparam int V_BITS     = 10;
    localparam int MIN_COUNT  = 4;
    localparam int LAT_EMPTY  = 2;
    localparam int LAT_TARGET = 2 + (2*H_BITS + V_BITS) + (H_BITS + 2*V_BITS);

    typedef struct {
        int due;
        int cx;
        int cy;
        int cnt;
        int found;
        int x0;
        int x1;
        int y0;
        int y1;
    } exp_t;

    logic                     CLK = 1'b0;
    logic                     RESET_N = 1'b0;
    logic                     VGA_VS = 1'b0;
    logic                     VGA_DE = 1'b0;
    logic                     BINARY_FLAG = 1'b0;
    logic [H_BITS-1:0]        CENTROID_X;
    logic [V_BITS-1:0]        CENTROID_Y;
    logic [H_BITS+V_BITS-1:0] PIXEL_COUNT;
    logic [H_BITS-1:0]        BBOX_X0;
    logic [H_BITS-1:0]        BBOX_X1;
    logic [V_BITS-1:0]        BBOX_Y0;
    logic [V_BITS-1:0]        BBOX_Y1;
    logic                     TARGET_FOUND;
    logic                     RESULT_VALID;

    binary_centroid #(
        .H_BITS(H_BITS), .V_BITS(V_BITS), .MIN_COUNT(MIN_COUNT)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
        .BINARY_FLAG(BINARY_FLAG), .CENTROID_X(CENTROID_X), .CENTROID_Y(CENTROID_Y),
        .PIXEL_COUNT(PIXEL_COUNT), .BBOX_X0(BBOX_X0), .BBOX_X1(BBOX_X1),
        .BBOX_Y0(BBOX_Y0), .BBOX_Y1(BBOX_Y1), .TARGET_FOUND(TARGET_FOUND),
        .RESULT_VALID(RESULT_VALID)
    );

    always #5 CLK = ~CLK;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t ref_e;
    exp_t mon_e;
    bit   hold_ok;

    bit   pix [0:7][0:15];
    int   m_cnt, m_sx, m_sy, m_x0, m_x1, m_y0, m_y1, m_line;
    bit   armed;
    int   last_e;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic exp_t zero_exp();
        exp_t z;
        z.due = 0; z.cx = 0; z.cy = 0; z.cnt = 0; z.found = 0;
        z.x0 = 0; z.x1 = 0; z.y0 = 0; z.y1 = 0;
        return z;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: reset state, scoreboard pops on RESULT_VALID, hold in between
    always @(negedge CLK) begin
        if (!RESET_N) begin
            n_cmp++;
            if (RESULT_VALID !== 1'b0 || CENTROID_X !== '0 || CENTROID_Y !== '0 ||
                PIXEL_COUNT !== '0 || TARGET_FOUND !== 1'b0 || BBOX_X0 !== '0 ||
                BBOX_X1 !== '0 || BBOX_Y0 !== '0 || BBOX_Y1 !== '0) begin
                n_fail++;
                $display("FAIL reset_state: got valid=%0d cx=%0d cy=%0d cnt=%0d found=%0d, expected all 0",
                         RESULT_VALID, CENTROID_X, CENTROID_Y, PIXEL_COUNT, TARGET_FOUND);
            end
            ref_e = zero_exp();
        end else begin
            if (q.size() > 0 && cyc > q[0].due) begin
                n_cmp++;
                n_fail++;
                $display("FAIL missing_valid: none by cycle %0d, expected at cycle %0d", cyc, q[0].due);
                void'(q.pop_front());
            end
            if (RESULT_VALID === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("latency",      cyc,               mon_e.due);
                    chk("centroid_x",   int'(CENTROID_X),  mon_e.cx);
                    chk("centroid_y",   int'(CENTROID_Y),  mon_e.cy);
                    chk("pixel_count",  int'(PIXEL_COUNT), mon_e.cnt);
                    chk("target_found", int'(TARGET_FOUND), mon_e.found);
                    chk("bbox_x0",      int'(BBOX_X0),     mon_e.x0);
                    chk("bbox_x1",      int'(BBOX_X1),     mon_e.x1);
                    chk("bbox_y0",      int'(BBOX_Y0),     mon_e.y0);
                    chk("bbox_y1",      int'(BBOX_Y1),     mon_e.y1);
                    ref_e = mon_e;
                end
            end else begin
                hold_ok = (int'(CENTROID_X) == ref_e.cx) && (int'(CENTROID_Y) == ref_e.cy) &&
                          (int'(PIXEL_COUNT) == ref_e.cnt) && (int'(TARGET_FOUND) == ref_e.found) &&
                          (int'(BBOX_X0) == ref_e.x0) && (int'(BBOX_X1) == ref_e.x1) &&
                          (int'(BBOX_Y0) == ref_e.y0) && (int'(BBOX_Y1) == ref_e.y1);
                n_cmp++;
                if (!hold_ok) begin
                    n_fail++;
                    $display("FAIL hold: got cx=%0d cy=%0d cnt=%0d found=%0d, expected cx=%0d cy=%0d cnt=%0d found=%0d",
                             CENTROID_X, CENTROID_Y, PIXEL_COUNT, TARGET_FOUND,
                             ref_e.cx, ref_e.cy, ref_e.cnt, ref_e.found);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        m_cnt = 0; m_sx = 0; m_sy = 0; m_line = 0;
        m_x0 = 1 << 30; m_x1 = -1; m_y0 = 1 << 30; m_y1 = -1;
    endtask

    task automatic clear_pix();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                pix[r][c] = 1'b0;
    endtask

    task automatic set_pix(input int x, input int y);
        pix[y][x] = 1'b1;
    endtask

    // Send h lines of w active pixels; the model tallies set pixels by (x, line)
    task automatic send_lines(input int w, input int h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                VGA_DE = 1'b1;
                BINARY_FLAG = pix[r][c];
                if (pix[r][c]) begin
                    m_cnt++;
                    m_sx += c;
                    m_sy += m_line;
                    if (c < m_x0) m_x0 = c;
                    if (c > m_x1) m_x1 = c;
                    if (m_line < m_y0) m_y0 = m_line;
                    if (m_line > m_y1) m_y1 = m_line;
                end
                tick();
            end
            VGA_DE = 1'b0;
            m_line++;
            for (int b = 0; b < 3; b++) begin
                BINARY_FLAG = 1'($urandom_range(0, 1));
                tick();
            end
        end
        BINARY_FLAG = 1'b0;
    endtask

    // Raise VS for two cycles; queue the result of the frame just closed
    task automatic vs_pulse(input int idle);
        exp_t e;
        VGA_DE = 1'b0;
        VGA_VS = 1'b1;
        last_e = cyc;
        if (armed) begin
            e.found = (m_cnt >= MIN_COUNT) ? 1 : 0;
            e.cnt   = m_cnt;
            e.due   = last_e + (e.found ? LAT_TARGET : LAT_EMPTY);
            e.cx    = e.found ? m_sx / m_cnt : 0;
            e.cy    = e.found ? m_sy / m_cnt : 0;
`ifdef BINARY_CENTROID_BBOX_EN
            e.x0 = e.found ? m_x0 : 0;
            e.x1 = e.found ? m_x1 : 0;
            e.y0 = e.found ? m_y0 : 0;
            e.y1 = e.found ? m_y1 : 0;
`else
            e.x0 = 0; e.x1 = 0; e.y0 = 0; e.y1 = 0;
`endif
            // a result still in flight when this frame is snapshotted is abandoned
            while (q.size() > 0 && q[$].due >= last_e + 2) void'(q.pop_back());
            q.push_back(e);
        end
        model_clear();
        armed = 1'b1;
        repeat (2) tick();
        VGA_VS = 1'b0;
        repeat (idle) tick();
    endtask

    task automatic pulse_reset();
        RESET_N = 1'b0;
        q.delete();
        armed = 1'b0;
        model_clear();
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic square_pattern();
        clear_pix();
        set_pix(2, 1); set_pix(4, 1); set_pix(2, 3); set_pix(4, 3);
    endtask

    initial begin
        int w, h, dens;
        armed = 1'b0;
        ref_e = zero_exp();
        model_clear();
        clear_pix();
        repeat (3) tick();
        RESET_N = 1'b1;
        tick();

        // traffic before the first VS is discarded; that VS only arms
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++)
                pix[r][c] = 1'($urandom_range(0, 1));
        send_lines(8, 3);
        vs_pulse(4);

        // 4-pixel square: centroid (3,2), bbox (2,1)-(4,3)
        square_pattern();
        send_lines(8, 4);
        vs_pulse(70);

        // 3 pixels: below threshold
        clear_pix();
        set_pix(1, 0); set_pix(5, 2); set_pix(7, 3);
        send_lines(8, 4);
        vs_pulse(70);

        // empty frame
        clear_pix();
        send_lines(8, 4);
        vs_pulse(70);

        // fractional means floor to 0
        clear_pix();
        set_pix(0, 0); set_pix(1, 0); set_pix(0, 1); set_pix(1, 1); set_pix(1, 2);
        send_lines(8, 4);
        vs_pulse(70);

        // two VS edges 10 cycles apart: target division abandoned
        square_pattern();
        send_lines(8, 4);
        vs_pulse(8);
        vs_pulse(70);

        // publish a non-zero target, then reset during the next DIV_Y
        square_pattern();
        send_lines(8, 4);
        vs_pulse(70);
        clear_pix();
        set_pix(6, 0); set_pix(7, 1); set_pix(6, 2); set_pix(5, 3); set_pix(3, 3);
        send_lines(8, 4);
        vs_pulse(0);
        while (cyc < last_e + 40) tick();
        pulse_reset();
        square_pattern();
        send_lines(8, 4);
        vs_pulse(4);
        clear_pix();
        set_pix(9, 1); set_pix(10, 2); set_pix(11, 5); set_pix(9, 5); set_pix(12, 0);
        send_lines(14, 6);
        vs_pulse(70);

        // randomized frames
        for (int k = 0; k < 8; k++) begin
            w = $urandom_range(4, 16);
            h = $urandom_range(2, 8);
            dens = $urandom_range(0, 60);
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 16; c++)
                    pix[r][c] = ($urandom_range(0, 99) < dens);
            send_lines(w, h);
            vs_pulse(70);
        end

        for (int i = 0; i < 200 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d results outstanding, expected 0", q.size());
        end
        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
